// File: rtl/axi_ic_pkg.sv
// Shared types and defaults for the AXI interconnect R-channel blocks.
package axi_ic_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_BURST = 1'b1
  } arb_state_e;

  localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or after ptr_i, wrapping.
module rr_pick #(
  parameter int NumSlaves  = 2,
  parameter int GrantWidth = 1
) (
  input  logic [NumSlaves-1:0]  req_i,
  input  logic [GrantWidth-1:0] ptr_i,
  output logic [NumSlaves-1:0]  onehot_o,
  output logic [GrantWidth-1:0] bin_o,
  output logic                  any_o
);

  // Outer loop walks priority order from ptr_i; inner loop keeps every index constant.
  always_comb begin
    onehot_o = '0;
    bin_o    = '0;
    any_o    = 1'b0;
    for (int i = 0; i < NumSlaves; i++) begin
      for (int j = 0; j < NumSlaves; j++) begin
        if (!any_o && req_i[j] && (((int'(ptr_i) + i) % NumSlaves) == j)) begin
          any_o       = 1'b1;
          onehot_o[j] = 1'b1;
          bin_o       = GrantWidth'(j);
        end
      end
    end
  end

endmodule

// File: rtl/axi_r_burst_arb.sv
// R-channel burst-locking round-robin arbiter: one slave owns the master port until rlast.
// Optional watchdog release is compiled in with AXI_R_ARB_TIMEOUT_EN.
module axi_r_burst_arb
  import axi_ic_pkg::*;
#(
  parameter  int NumSlaves     = 2,
  parameter  int TimeoutCycles = TIMEOUT_CYCLES_DEF,
  localparam int GrantWidth    = (NumSlaves > 1) ? $clog2(NumSlaves) : 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [NumSlaves-1:0]  rvalid_i,
  input  logic [NumSlaves-1:0]  rlast_i,
  input  logic                  rready_i,
  output logic                  valid_o,
  output logic [NumSlaves-1:0]  rready_o,
  output logic [NumSlaves-1:0]  grant_o,
  output logic [GrantWidth-1:0] bin_grant_o,
  output logic                  locked_o,
  output logic [7:0]            beat_cnt_o,
  output logic                  timeout_err_o
);

  if (TimeoutCycles < 2) begin : g_bad_timeout
    $error("TimeoutCycles must be at least 2");
  end

  arb_state_e            r_state;
  logic [NumSlaves-1:0]  r_grant;
  logic [GrantWidth-1:0] r_bin;
  logic [GrantWidth-1:0] r_rr_ptr;
  logic [7:0]            r_beat;

  logic                  w_locked;
  logic                  w_hs;
  logic                  w_last;
  logic [GrantWidth-1:0] w_next_ptr;
  logic [NumSlaves-1:0]  w_pick_req;
  logic [GrantWidth-1:0] w_pick_ptr;
  logic [NumSlaves-1:0]  w_onehot;
  logic [GrantWidth-1:0] w_bin;
  logic                  w_any;

  assign w_locked   = (r_state == ST_BURST);
  assign valid_o    = w_locked & |(r_grant & rvalid_i);
  assign rready_o   = w_locked ? (r_grant & {NumSlaves{rready_i}}) : '0;
  assign w_hs       = valid_o & rready_i;
  assign w_last     = |(r_grant & rlast_i);
  assign w_next_ptr = (r_bin == GrantWidth'(NumSlaves - 1)) ? '0 : r_bin + GrantWidth'(1);

  // While locked the picker serves the rlast re-arbitration: finished slave excluded.
  assign w_pick_req = w_locked ? (rvalid_i & ~r_grant) : rvalid_i;
  assign w_pick_ptr = w_locked ? w_next_ptr : r_rr_ptr;

  rr_pick #(
    .NumSlaves (NumSlaves),
    .GrantWidth(GrantWidth)
  ) u_pick (
    .req_i   (w_pick_req),
    .ptr_i   (w_pick_ptr),
    .onehot_o(w_onehot),
    .bin_o   (w_bin),
    .any_o   (w_any)
  );

`ifdef AXI_R_ARB_TIMEOUT_EN
  localparam int WdW = $clog2(TimeoutCycles);
  logic [WdW-1:0] r_wdog;
  logic           r_tmo;
  assign timeout_err_o = r_tmo;
`else
  assign timeout_err_o = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_bin    <= '0;
      r_rr_ptr <= '0;
      r_beat   <= '0;
`ifdef AXI_R_ARB_TIMEOUT_EN
      r_wdog   <= '0;
      r_tmo    <= 1'b0;
`endif
    end else begin
`ifdef AXI_R_ARB_TIMEOUT_EN
      r_tmo <= 1'b0;
`endif
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_state <= ST_BURST;
            r_grant <= w_onehot;
            r_bin   <= w_bin;
            r_beat  <= '0;
`ifdef AXI_R_ARB_TIMEOUT_EN
            r_wdog  <= '0;
`endif
          end
        end
        ST_BURST: begin
          if (w_hs) begin
`ifdef AXI_R_ARB_TIMEOUT_EN
            r_wdog <= '0;
`endif
            if (r_beat != 8'hFF) r_beat <= r_beat + 8'd1;
            if (w_last) begin
              r_rr_ptr <= w_next_ptr;
              if (w_any) begin
                r_grant <= w_onehot;
                r_bin   <= w_bin;
                r_beat  <= '0;
              end else begin
                r_state <= ST_IDLE;
                r_grant <= '0;
                r_bin   <= '0;
              end
            end
          end
`ifdef AXI_R_ARB_TIMEOUT_EN
          else if (r_wdog == WdW'(TimeoutCycles - 1)) begin
            r_tmo    <= 1'b1;
            r_rr_ptr <= w_next_ptr;
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_bin    <= '0;
            r_wdog   <= '0;
          end else begin
            r_wdog <= r_wdog + WdW'(1);
          end
`endif
        end
      endcase
    end
  end

  assign grant_o     = r_grant;
  assign bin_grant_o = r_bin;
  assign locked_o    = w_locked;
  assign beat_cnt_o  = r_beat;

endmodule

// File: tb/tb_axi_r_burst_arb.sv
// Directed cycle-trace bench for axi_r_burst_arb (NumSlaves=2, default build).
module tb_axi_r_burst_arb;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [1:0] rvalid_i, rlast_i;
  logic       rready_i;
  logic       valid_o;
  logic [1:0] rready_o, grant_o;
  logic [0:0] bin_grant_o;
  logic       locked_o;
  logic [7:0] beat_cnt_o;
  logic       timeout_err_o;

  int checks = 0;
  int failures = 0;

  always #5 clk_i = ~clk_i;

  axi_r_burst_arb #(.NumSlaves(2)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .rvalid_i     (rvalid_i),
    .rlast_i      (rlast_i),
    .rready_i     (rready_i),
    .valid_o      (valid_o),
    .rready_o     (rready_o),
    .grant_o      (grant_o),
    .bin_grant_o  (bin_grant_o),
    .locked_o     (locked_o),
    .beat_cnt_o   (beat_cnt_o),
    .timeout_err_o(timeout_err_o)
  );

  typedef struct {
    logic       rst;
    logic [1:0] rv;
    logic [1:0] rl;
    logic       rdy;
    logic       ev;
    logic [1:0] err;
    logic [1:0] eg;
    logic       eb;
    logic       el;
    logic [7:0] ebeat;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [1:0] rv, logic [1:0] rl, logic rdy,
                              logic ev, logic [1:0] err, logic [1:0] eg, logic eb,
                              logic el, logic [7:0] ebeat);
    vec_t v;
    v.rst = rst; v.rv = rv; v.rl = rl; v.rdy = rdy;
    v.ev = ev; v.err = err; v.eg = eg; v.eb = eb; v.el = el; v.ebeat = ebeat;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Drive on the falling edge, then settle before sampling.
  task automatic step(input logic rst, input logic [1:0] rv, input logic [1:0] rl,
                      input logic rdy);
    @(negedge clk_i);
    rst_i = rst; rvalid_i = rv; rlast_i = rl; rready_i = rdy;
    #1;
  endtask

  initial begin
    logic bad;
    // Reset and single slave0 4-beat burst
    tbl.push_back(mk(1, 2'b00, 2'b00, 0,  0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 1,  0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 1,  1, 2'b01, 2'b01, 0, 1, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 1,  1, 2'b01, 2'b01, 0, 1, 1));
    tbl.push_back(mk(0, 2'b01, 2'b00, 1,  1, 2'b01, 2'b01, 0, 1, 2));
    tbl.push_back(mk(0, 2'b01, 2'b01, 1,  1, 2'b01, 2'b01, 0, 1, 3));
    tbl.push_back(mk(0, 2'b00, 2'b00, 1,  0, 2'b00, 2'b00, 0, 0, 4));
    // Reset hits at beat 2 of a longer burst
    tbl.push_back(mk(0, 2'b01, 2'b00, 1,  0, 2'b00, 2'b00, 0, 0, 4));
    tbl.push_back(mk(0, 2'b01, 2'b00, 1,  1, 2'b01, 2'b01, 0, 1, 0));
    tbl.push_back(mk(0, 2'b01, 2'b00, 1,  1, 2'b01, 2'b01, 0, 1, 1));
    tbl.push_back(mk(1, 2'b01, 2'b00, 1,  1, 2'b01, 2'b01, 0, 1, 2));
    tbl.push_back(mk(0, 2'b00, 2'b00, 1,  0, 2'b00, 2'b00, 0, 0, 0));
    // Both request with ptr 0: zero-bubble handover on rlast
    tbl.push_back(mk(0, 2'b11, 2'b00, 1,  0, 2'b00, 2'b00, 0, 0, 0));
    tbl.push_back(mk(0, 2'b11, 2'b00, 1,  1, 2'b01, 2'b01, 0, 1, 0));
    tbl.push_back(mk(0, 2'b11, 2'b01, 1,  1, 2'b01, 2'b01, 0, 1, 1));
    tbl.push_back(mk(0, 2'b10, 2'b00, 1,  1, 2'b10, 2'b10, 1, 1, 0));
    tbl.push_back(mk(0, 2'b10, 2'b10, 1,  1, 2'b10, 2'b10, 1, 1, 1));
    tbl.push_back(mk(0, 2'b00, 2'b00, 1,  0, 2'b00, 2'b00, 0, 0, 2));
    // Granted rvalid gap with competitor, then rready stall
    tbl.push_back(mk(0, 2'b01, 2'b00, 1,  0, 2'b00, 2'b00, 0, 0, 2));
    tbl.push_back(mk(0, 2'b01, 2'b00, 1,  1, 2'b01, 2'b01, 0, 1, 0));
    for (int k = 0; k < 3; k++)
      tbl.push_back(mk(0, 2'b10, 2'b00, 1,  0, 2'b01, 2'b01, 0, 1, 1));
    for (int k = 0; k < 5; k++)
      tbl.push_back(mk(0, 2'b11, 2'b00, 0,  1, 2'b00, 2'b01, 0, 1, 1));
    tbl.push_back(mk(0, 2'b11, 2'b01, 1,  1, 2'b01, 2'b01, 0, 1, 1));
    tbl.push_back(mk(0, 2'b10, 2'b10, 1,  1, 2'b10, 2'b10, 1, 1, 0));
    tbl.push_back(mk(0, 2'b00, 2'b00, 1,  0, 2'b00, 2'b00, 0, 0, 1));

    rst_i = 1'b1; rvalid_i = '0; rlast_i = '0; rready_i = 1'b0;
    repeat (2) @(posedge clk_i);

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].rv, tbl[i].rl, tbl[i].rdy);
      chk($sformatf("row%0d.valid", i),  32'(valid_o),       32'(tbl[i].ev));
      chk($sformatf("row%0d.rready", i), 32'(rready_o),      32'(tbl[i].err));
      chk($sformatf("row%0d.grant", i),  32'(grant_o),       32'(tbl[i].eg));
      chk($sformatf("row%0d.bin", i),    32'(bin_grant_o),   32'(tbl[i].eb));
      chk($sformatf("row%0d.locked", i), 32'(locked_o),      32'(tbl[i].el));
      chk($sformatf("row%0d.beat", i),   32'(beat_cnt_o),    32'(tbl[i].ebeat));
      chk($sformatf("row%0d.tmo", i),    32'(timeout_err_o), 32'd0);
    end

    // Lock held through a long stall with a competitor (no watchdog in this build)
    step(0, 2'b10, 2'b00, 1);
    bad = 1'b0;
    for (int k = 0; k < 1100; k++) begin
      step(0, 2'b01, 2'b00, 1);
      if (grant_o !== 2'b10 || locked_o !== 1'b1 || rready_o !== 2'b10 ||
          valid_o !== 1'b0 || timeout_err_o !== 1'b0) bad = 1'b1;
    end
    chk("stall_lock_held", 32'(bad), 32'd0);
    chk("stall_grant", 32'(grant_o), 32'h2);

    // Beat counter saturates at 255
    for (int k = 0; k < 300; k++) step(0, 2'b10, 2'b00, 1);
    step(0, 2'b11, 2'b10, 1);
    chk("sat_beat", 32'(beat_cnt_o), 32'd255);
    chk("sat_valid", 32'(valid_o), 32'd1);
    step(0, 2'b01, 2'b01, 1);
    chk("handover_grant", 32'(grant_o), 32'h1);
    chk("handover_beat", 32'(beat_cnt_o), 32'd0);
    chk("handover_locked", 32'(locked_o), 32'd1);
    step(0, 2'b00, 2'b00, 1);
    chk("final_locked", 32'(locked_o), 32'd0);
    chk("final_grant", 32'(grant_o), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
